// File: rtl/cnn_mem_pkg.sv
// Shared types and constants for the CNN engine to BRAM memory path.
package cnn_mem_pkg;

    localparam int N_REQ_DEF   = 3;
    localparam int REQ_ID_W    = $clog2(N_REQ_DEF);
    localparam int BRAM_RD_LAT = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } bram_cmd_t;

    // Requester-id width that stays at least one bit wide.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters; search starts at the pointer, which
// advances past the winner unless held.
module rr_arbiter
    import cnn_mem_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req,
    input  logic                    hold,
    output logic [N-1:0]            grant,
    output logic [id_width(N)-1:0]  grant_id
);
    localparam int ID_W = id_width(N);

    logic [ID_W-1:0] ptr;
    logic            grant_any;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any && !hold) begin
            ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between N_REQ engines: round-robin with burst
// lock, registered BRAM command, read data routed back to the issuing requester.
//
// state       | meaning
// ST_UNLOCKED | round-robin among all valid requesters
// ST_LOCKED   | only owner may be granted while it holds req_valid; pointer frozen
module bram_port_arbiter
    import cnn_mem_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WE_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*WE_W-1:0]     req_we,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         BRAM_ADDR,
    output logic                      BRAM_EN,
    output logic [WE_W-1:0]           BRAM_WE,
    output logic [DATA_W-1:0]         BRAM_DIN,
    input  logic [DATA_W-1:0]         BRAM_DOUT,
    output logic                      BRAM_RST
);
    localparam int ID_W   = id_width(N_REQ);
    localparam int PIPE_D = BRAM_RD_LAT + 1;

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WE_W-1:0]   we;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic            rd;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [0:0]       lock_st;
    logic [ID_W-1:0]  owner;
    logic             lock_active;
    logic [N_REQ-1:0] rr_grant;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  rr_id;
    logic [ID_W-1:0]  sel_id;
    logic             accept;
    cmd_t             cmd_in [N_REQ];
    cmd_t             sel_cmd;
    cmd_t             cmd_q;
    logic             en_q;
    tag_t             pipe [PIPE_D];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign cmd_in[g].addr  = req_addr[g*ADDR_W +: ADDR_W];
        assign cmd_in[g].we    = req_we[g*WE_W +: WE_W];
        assign cmd_in[g].wdata = req_wdata[g*DATA_W +: DATA_W];
    end

    // A lock only binds while its owner keeps valid high; otherwise RR resumes this cycle.
    assign lock_active = (lock_st == ST_LOCKED) && req_valid[owner];

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .hold     (lock_active),
        .grant    (rr_grant),
        .grant_id (rr_id)
    );

    always_comb begin
        grant  = rr_grant;
        sel_id = rr_id;
        if (lock_active) begin
            grant        = '0;
            grant[owner] = 1'b1;
            sel_id       = owner;
        end
    end

    assign req_ready = grant & req_valid;
    assign accept    = |req_ready;
    assign sel_cmd   = cmd_in[sel_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_st <= ST_UNLOCKED;
            owner   <= '0;
        end else if (accept) begin
            lock_st <= req_lock[sel_id] ? ST_LOCKED : ST_UNLOCKED;
            owner   <= sel_id;
        end else begin
            lock_st <= ST_UNLOCKED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q  <= 1'b0;
            cmd_q <= '0;
        end else begin
            en_q <= accept;
            if (accept) cmd_q    <= sel_cmd;
            else        cmd_q.we <= '0;
        end
    end

    // Tag travels alongside the BRAM access so the read data lands on its issuer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_D; k++) pipe[k] <= '0;
        end else begin
            pipe[0].rd <= accept && (sel_cmd.we == '0);
            pipe[0].id <= sel_id;
            for (int k = 1; k < PIPE_D; k++) pipe[k] <= pipe[k-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (pipe[PIPE_D-1].rd) begin
            rsp_valid[pipe[PIPE_D-1].id] = 1'b1;
            rsp_rdata                    = BRAM_DOUT;
        end
    end

    assign BRAM_ADDR = cmd_q.addr;
    assign BRAM_WE   = cmd_q.we;
    assign BRAM_DIN  = cmd_q.wdata;
    assign BRAM_EN   = en_q;
    assign BRAM_RST  = 1'b0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: reference arbitration/memory model,
// BRAM behavioural model, directed scenarios then random traffic.
module tb_bram_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid, req_ready, req_lock, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*WW-1:0] req_we;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, BRAM_DIN, BRAM_DOUT;
    logic [AW-1:0]   BRAM_ADDR;
    logic [WW-1:0]   BRAM_WE;
    logic            BRAM_EN, BRAM_RST;

    logic [AW-1:0] r_addr [N];
    logic [WW-1:0] r_we   [N];
    logic [DW-1:0] r_wd   [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*AW +: AW]  = r_addr[g];
        assign req_we[g*WW +: WW]    = r_we[g];
        assign req_wdata[g*DW +: DW] = r_wd[g];
    end

    bram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WE_W(WW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
        .BRAM_DIN(BRAM_DIN), .BRAM_DOUT(BRAM_DOUT), .BRAM_RST(BRAM_RST)
    );

    always #5 clk = ~clk;

    // BRAM: registered read-first output, byte-enabled write.
    logic [DW-1:0] mem [64];
    logic          mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 64; k++) mem[k] <= '0;
        end else if (BRAM_EN) begin
            BRAM_DOUT <= mem[BRAM_ADDR[7:2]];
            for (int b = 0; b < WW; b++)
                if (BRAM_WE[b]) mem[BRAM_ADDR[7:2]][8*b +: 8] <= BRAM_DIN[8*b +: 8];
        end
    end

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb [$];
    int            gnt_log [$];
    logic [DW-1:0] ref_mem [64];
    int            m_ptr = 0, m_owner = 0;
    bit            m_locked = 0;
    bit            en_exp = 0;
    logic [AW-1:0] addr_exp;
    logic [WW-1:0] we_exp;
    logic [DW-1:0] din_exp;
    int            n_vec = 0, n_err = 0, cyc = 0, acc_id = -1, last_id = -1;
    logic [DW-1:0] last_rdata = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lock owner wins while still valid; otherwise first valid from the pointer.
    function automatic int model_pick();
        if (m_locked && req_valid[m_owner]) return m_owner;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_values",
                  {req_ready, rsp_valid, rsp_rdata, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN}, '0);
        end else begin
            int            j;
            int            w;
            logic [N-1:0]  exp_rdy;
            check("bram_en", BRAM_EN, en_exp);
            if (en_exp) check("bram_cmd", {BRAM_ADDR, BRAM_WE, BRAM_DIN}, {addr_exp, we_exp, din_exp});
            else        check("bram_we_idle", BRAM_WE, '0);
            j = model_pick();
            exp_rdy = '0;
            if (j >= 0) exp_rdy[j] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            for (int i = 0; i < N; i++) if (req_ready[i]) gnt_log.push_back(i);
            if (j >= 0) begin
                if (!(m_locked && req_valid[m_owner])) m_ptr = (j + 1) % N;
                m_locked = req_lock[j];
                m_owner  = j;
                en_exp   = 1'b1;
                addr_exp = r_addr[j];
                we_exp   = r_we[j];
                din_exp  = r_wd[j];
                w = int'(r_addr[j][7:2]);
                if (r_we[j] == '0) sb.push_back('{j, ref_mem[w], cyc + 2});
                else for (int b = 0; b < WW; b++)
                    if (r_we[j][b]) ref_mem[w][8*b +: 8] = r_wd[j][8*b +: 8];
            end else begin
                m_locked = 1'b0;
                en_exp   = 1'b0;
            end
            acc_id = j;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_t         e;
            logic [N-1:0] oh;
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, '0);
                end else begin
                    e = sb.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    check("rsp_valid", rsp_valid, oh);
                    check("rsp_rdata", rsp_rdata, e.data);
                    check("rsp_cycle", cyc, e.due);
                end
                last_rdata = rsp_rdata;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) last_id = i;
            end else begin
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    check("rsp_missing", rsp_valid, oh);
                end
                check("rsp_rdata_idle", rsp_rdata, '0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit lk, input logic [31:0] a,
                           input logic [3:0] we, input logic [31:0] d);
        req_valid[i] = v;
        req_lock[i]  = lk;
        r_addr[i]    = a;
        r_we[i]      = we;
        r_wd[i]      = d;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_lock  = '0;
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        idle_all();
        sb.delete();
        m_ptr = 0;
        m_owner = 0;
        m_locked = 1'b0;
        en_exp = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        check({name, "_len"}, gnt_log.size(), exp.size());
        for (int k = 0; k < exp.size() && k < gnt_log.size(); k++)
            check(name, gnt_log[k], exp[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int w;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
        for (int k = 0; k < 64; k++) ref_mem[k] = '0;
        do_reset(3);
        mem_clr = 1'b0;
        check("bram_rst", BRAM_RST, 1'b0);

        // full contention, pointer starts at 0
        set_req(0, 1, 0, 32'h0, 4'h0, 0);
        set_req(1, 1, 0, 32'h4, 4'h0, 0);
        set_req(2, 1, 0, 32'h8, 4'h0, 0);
        gnt_log.delete();
        repeat (6) tick();
        idle_all();
        check_seq("contention_order", '{0, 1, 2, 0, 1, 2});
        repeat (3) tick();

        // single read of a preloaded word
        set_req(0, 1, 0, 32'h10, 4'hF, 32'hDEADBEEF);
        tick();
        idle_all();
        set_req(1, 1, 0, 32'h10, 4'h0, 0);
        tick();
        idle_all();
        repeat (3) tick();
        check("single_read_data", last_rdata, 32'hDEADBEEF);
        check("single_read_id", last_id, 1);

        // burst lock from requester 2 (pointer now at 2)
        set_req(0, 1, 0, 32'h0, 4'h0, 0);
        set_req(1, 1, 0, 32'h4, 4'h0, 0);
        set_req(2, 1, 1, 32'h30, 4'h0, 0);
        gnt_log.delete();
        repeat (3) tick();
        req_lock[2] = 1'b0;
        tick();
        req_valid[2] = 1'b0;
        tick();
        req_valid[0] = 1'b0;
        tick();
        idle_all();
        check_seq("burst_lock", '{2, 2, 2, 2, 0, 1});
        repeat (3) tick();

        // lock dropped by deasserting valid
        set_req(0, 1, 1, 32'h0, 4'h0, 0);
        set_req(1, 1, 0, 32'h4, 4'h0, 0);
        gnt_log.delete();
        repeat (2) tick();
        req_valid[0] = 1'b0;
        tick();
        idle_all();
        check_seq("lock_drop", '{0, 0, 1});
        repeat (3) tick();

        // write then read, full and partial byte enables
        set_req(0, 1, 0, 32'h20, 4'hF, 32'h12345678);
        tick();
        idle_all();
        set_req(1, 1, 0, 32'h20, 4'h0, 0);
        tick();
        idle_all();
        repeat (3) tick();
        check("wr_rd_full", last_rdata, 32'h12345678);
        set_req(0, 1, 0, 32'h20, 4'h1, 32'h000000AB);
        tick();
        idle_all();
        set_req(1, 1, 0, 32'h20, 4'h0, 0);
        tick();
        idle_all();
        repeat (3) tick();
        check("wr_rd_partial", last_rdata, 32'h123456AB);

        // reset one cycle after a read is accepted
        set_req(1, 1, 0, 32'h20, 4'h0, 0);
        tick();
        do_reset(2);
        repeat (3) tick();
        set_req(0, 1, 0, 32'h0, 4'h0, 0);
        set_req(1, 1, 0, 32'h4, 4'h0, 0);
        set_req(2, 1, 0, 32'h8, 4'h0, 0);
        gnt_log.delete();
        tick();
        idle_all();
        check("rst_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
        repeat (3) tick();

        // random traffic; requests stay stable until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc_id == i) begin
                    if ($urandom_range(0, 3) != 0) begin
                        w = int'($urandom_range(0, 63));
                        set_req(i, 1, ($urandom_range(0, 2) == 0),
                                32'(w * 4),
                                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                                $urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                        req_lock[i]  = 1'b0;
                    end
                end
            end
            tick();
        end
        idle_all();
        repeat (6) tick();
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM (IF, W or TEMP buffer) between up to N_REQ CNN engine requesters, e.g. conv, pool and fc stages all accessing TEMP.
- Performs round-robin arbitration with optional burst lock, drives the BRAM_* port from registers, and routes read data back to the requester that issued the read.
- Sits between the cnn compute engines and the bram instances.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 32, BRAM byte-address width
- DATA_W, 32, BRAM data width
- WE_W, 4, byte write-enable width (DATA_W/8)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester command valid
- req_ready  out  N_REQ  per-requester command accepted this cycle
- req_lock  in  N_REQ  hold grant after this beat (burst)
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_we  in  N_REQ*WE_W  packed byte write enables; all-zero = read
- req_wdata  in  N_REQ*DATA_W  packed write data
- rsp_valid  out  N_REQ  one-hot read-data valid
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- BRAM_ADDR  out  ADDR_W  to BRAM
- BRAM_EN  out  1  to BRAM
- BRAM_WE  out  WE_W  to BRAM
- BRAM_DIN  out  DATA_W  to BRAM
- BRAM_DOUT  in  DATA_W  from BRAM; valid the cycle after an EN edge
- BRAM_RST  out  1  constant 0

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DIN=0. RR pointer = 0, so requester 0 has highest priority. Lock state = unlocked.
- Grant is combinational from req_valid, the RR pointer and the lock state. At most one req_ready bit is high per cycle. req_ready[i] = grant[i] & req_valid[i].
- Beat accepted in cycle t (valid & ready):
  - t+1: BRAM_EN=1, with BRAM_ADDR/WE/DIN registered from the accepted requester.
  - t+2, reads only: rsp_valid[i]=1 and rsp_rdata = BRAM_DOUT.
  - Read latency is 2 cycles. Writes produce no response.
  - Throughput is one beat per cycle with no bubbles.
- When no beat is accepted: BRAM_EN=0 and BRAM_WE=0 next cycle. ADDR/DIN hold their previous values.
- RR pointer update: after an accepted unlocked beat from requester i, the pointer becomes (i+1) mod N_REQ. Search order starts at the pointer.
- Lock state machine, states UNLOCKED and LOCKED(owner):
  - UNLOCKED -> LOCKED(i) when requester i's beat is accepted with req_lock[i]=1.
  - In LOCKED(i), only requester i can be granted, and the pointer is frozen.
  - LOCKED(i) -> UNLOCKED on an accepted beat with req_lock[i]=0, or in any cycle where req_valid[i]=0 (lock dropped). In the req_valid[i]=0 case, RR arbitration resumes the same cycle from the pointer (i+1).
- Response routing: a 2-stage pipeline of {owner id, is_read}. rsp_rdata stays 0-held unless rsp_valid is set, in which case it equals BRAM_DOUT.
- Write followed by read to the same address in consecutive beats: the read returns the new data. This needs no forwarding, because the BRAM write completes before the read edge.
- Reset asserted mid-operation: the pipeline is cleared immediately and in-flight reads are dropped (no rsp_valid). The lock is cleared and the pointer returns to 0.
- Requesters must keep addr/we/wdata stable while valid and not ready. The arbiter does not check this.

Decomposition:
- Package cnn_mem_pkg holds:
  - localparam REQ_ID_W = clog2(N_REQ)
  - a bram_cmd_t struct {addr, we, wdata}
  - the constant BRAM_RD_LAT = 1
- Sub-module rr_arbiter (N parameter) contains the combinational grant plus the pointer register with hold input. bram_port_arbiter instantiates it and adds the lock FSM, command register and response pipeline.

Test Plan:
- Single read: mem[0x10]=0xDEADBEEF; req1 reads 0x10 in cycle t -> BRAM_EN=1 and ADDR=0x10 at t+1; rsp_valid=3'b010 and rsp_rdata=0xDEADBEEF at t+2.
- Full contention: all three requesters hold valid reads to addresses 0x0/0x4/0x8 for 6 cycles -> grant sequence 0,1,2,0,1,2. rsp_valid follows the same order 2 cycles later.
- Burst lock: req2 issues 4 beats with lock=1,1,1,0 while req0 and req1 are valid -> grants 2,2,2,2,0,1.
- Lock dropped: req0 locks, then deasserts valid for one cycle with req1 valid -> req1 is granted that same cycle.
- Write-then-read: req0 writes 0x12345678 with WE=4'hF to 0x20, req1 reads 0x20 the next beat -> rsp_rdata=0x12345678 to req1. A partial write with WE=4'h1 of 0xAB changes only byte 0.
- Reset at t+1 of an in-flight read -> rsp_valid stays 0, BRAM_EN=0, and the next arbitration grants requester 0 first.
